// File: rtl/coproc_pkg.sv
// Shared sizes and loader state type for the matrix coprocessor.
package coproc_pkg;
  localparam int unsigned MAT_DIM  = 5;
  localparam int unsigned ELEM_W   = 8;
  localparam int unsigned ELEM_CNT = MAT_DIM * MAT_DIM;
  localparam int unsigned FLAT_W   = ELEM_CNT * ELEM_W;
  localparam int unsigned IDX_W    = 5;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } loader_state_t;

  function automatic logic is_last_elem(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(ELEM_CNT - 1);
  endfunction
endpackage

// File: rtl/matrix_elem_reg.sv
// Flat matrix register with single-byte indexed write and synchronous active-low clear.
module matrix_elem_reg
  import coproc_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [ELEM_W-1:0] data,
  output logic [FLAT_W-1:0] q
);

  logic [FLAT_W-1:0] r_q;

  // Decoded per-byte enables keep every part-select in range for idx 25..31.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_q <= '0;
    end else begin
      for (int unsigned i = 0; i < ELEM_CNT; i++) begin
        if (wr_en && (idx == IDX_W'(i))) begin
          r_q[i*ELEM_W +: ELEM_W] <= data;
        end
      end
    end
  end

  assign q = r_q;

endmodule

// File: rtl/matrix_operand_loader.sv
// Streams two 5x5 signed-byte matrices (A then B) into flat operand registers and holds them.
// Optional MATRIX_LOADER_REUSE_B_EN adds reuse_b: skip the B load and keep the previous B.
module matrix_operand_loader
  import coproc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_data,
  output logic              in_ready,
  input  logic              abort,
  output logic [FLAT_W-1:0] A_flat,
  output logic [FLAT_W-1:0] B_flat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  elem_idx,
  output logic              loading_b
`ifdef MATRIX_LOADER_REUSE_B_EN
  ,
  input  logic              reuse_b
`endif
);

  loader_state_t    r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             w_accept, w_wr_a, w_wr_b, w_reuse_b;

`ifdef MATRIX_LOADER_REUSE_B_EN
  assign w_reuse_b = reuse_b;
`else
  assign w_reuse_b = 1'b0;
`endif

  assign in_ready = rst_n & ~abort & (r_state != HOLD);
  assign w_accept = in_valid & in_ready;
  assign w_wr_a   = w_accept & (r_state == LOAD_A);
  assign w_wr_b   = w_accept & (r_state == LOAD_B);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (abort) begin
      w_state_nxt = LOAD_A;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        LOAD_A: if (w_accept) begin
          if (is_last_elem(r_idx)) begin
            w_idx_nxt   = '0;
            w_state_nxt = w_reuse_b ? HOLD : LOAD_B;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        LOAD_B: if (w_accept) begin
          if (is_last_elem(r_idx)) begin
            w_idx_nxt   = '0;
            w_state_nxt = HOLD;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        HOLD: if (out_ready) begin
          w_state_nxt = LOAD_A;
          w_idx_nxt   = '0;
        end
        default: begin
          w_state_nxt = LOAD_A;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LOAD_A;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  matrix_elem_reg u_mat_a (
    .clk   (clk),
    .clr_n (rst_n),
    .wr_en (w_wr_a),
    .idx   (r_idx),
    .data  (in_data),
    .q     (A_flat)
  );

  matrix_elem_reg u_mat_b (
    .clk   (clk),
    .clr_n (rst_n),
    .wr_en (w_wr_b),
    .idx   (r_idx),
    .data  (in_data),
    .q     (B_flat)
  );

  assign out_valid = (r_state == HOLD);
  assign loading_b = (r_state == LOAD_B);
  assign elem_idx  = r_idx;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Self-checking bench for matrix_operand_loader: vector table, directed corner sequences,
// and randomized traffic against a load-position model (define MATRIX_LOADER_REUSE_B_EN for reuse_b).
module tb_matrix_operand_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_ready;
  logic         abort = 1'b0;
  logic [199:0] A_flat, B_flat;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [4:0]   elem_idx;
  logic         loading_b;
  logic         reuse_b = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matrix_operand_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .abort     (abort),
    .A_flat    (A_flat),
    .B_flat    (B_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .elem_idx  (elem_idx),
    .loading_b (loading_b)
`ifdef MATRIX_LOADER_REUSE_B_EN
    ,
    .reuse_b   (reuse_b)
`endif
  );

  // Reference model: position 0..49 within a two-matrix load, plus a "holding" flag.
  logic [7:0] m_a[25];
  logic [7:0] m_b[25];
  int         m_pos  = 0;
  bit         m_hold = 1'b0;

  function automatic bit reuse_active();
`ifdef MATRIX_LOADER_REUSE_B_EN
    return reuse_b;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_pos = 0; m_hold = 0;
      for (int i = 0; i < 25; i++) begin m_a[i] = '0; m_b[i] = '0; end
    end else if (abort) begin
      m_pos = 0; m_hold = 0;
    end else if (m_hold) begin
      if (out_ready) begin m_hold = 0; m_pos = 0; end
    end else if (in_valid) begin
      if (m_pos < 25) m_a[m_pos] = in_data;
      else            m_b[m_pos - 25] = in_data;
      m_pos++;
      if (m_pos == 50 || (m_pos == 25 && reuse_active())) begin
        m_hold = 1; m_pos = 0;
      end
    end
  endtask

  function automatic logic [199:0] pack(input bit is_b);
    logic [199:0] f;
    f = '0;
    for (int i = 0; i < 25; i++) f[i*8 +: 8] = is_b ? m_b[i] : m_a[i];
    return f;
  endfunction

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_outs();
    chk("out_valid", 200'(out_valid), 200'(m_hold));
    chk("elem_idx",  200'(elem_idx),  200'(m_pos % 25));
    chk("loading_b", 200'(loading_b), 200'(!m_hold && m_pos >= 25));
    chk("A_flat", A_flat, pack(1'b0));
    chk("B_flat", B_flat, pack(1'b1));
  endtask

  // One clock: check in_ready against current inputs, clock, then check registered outputs.
  task automatic cyc();
    #1;
    chk("in_ready", 200'(in_ready), 200'(rst_n && !abort && !m_hold));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic drive(input logic rn, input logic iv, input logic [7:0] d,
                       input logic ab, input logic ordy);
    rst_n = rn; in_valid = iv; in_data = d; abort = ab; out_ready = ordy;
  endtask

  typedef struct {
    logic       rn, iv;
    logic [7:0] d;
    logic       ab, ordy;
    logic       e_ready;
    logic [4:0] e_idx;
    logic       e_lb, e_ov;
  } vec_t;

  vec_t         tbl[9];
  logic [199:0] save_a, save_b;
  logic [7:0]   alt;

  initial begin
    for (int i = 0; i < 25; i++) begin m_a[i] = '0; m_b[i] = '0; end

    tbl[0] = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 8'h09, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rn, tbl[i].iv, tbl[i].d, tbl[i].ab, tbl[i].ordy);
      #1;
      if (i > 0) chk("tbl_in_ready", 200'(in_ready), 200'(tbl[i].e_ready));
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("tbl_elem_idx",  200'(elem_idx),  200'(tbl[i].e_idx));
      chk("tbl_loading_b", 200'(loading_b), 200'(tbl[i].e_lb));
      chk("tbl_out_valid", 200'(out_valid), 200'(tbl[i].e_ov));
      if (i == 7) chk("tbl_A_low3", A_flat[23:0], 200'(24'h000204));
      check_outs();
    end

    // Full-rate stream 1..50, out_valid one cycle after the 50th beat.
    for (int i = 1; i <= 50; i++) begin
      drive(1, 1, 8'(i), 0, 0);
      cyc();
      if (i == 49) chk("stream_ov_early", 200'(out_valid), 200'(0));
      if (i == 25) chk("stream_ab_switch", 200'(loading_b), 200'(1));
    end
    chk("stream_ov",     200'(out_valid),      200'(1));
    chk("stream_A0",     200'(A_flat[7:0]),    200'(1));
    chk("stream_A24",    200'(A_flat[199:192]), 200'(25));
    chk("stream_B0",     200'(B_flat[7:0]),    200'(26));

    // HOLD ignores traffic until out_ready.
    save_a = A_flat; save_b = B_flat;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 8'h7F, 0, 0);
      cyc();
    end
    chk("hold_A", A_flat, save_a);
    chk("hold_B", B_flat, save_b);
    chk("hold_ov", 200'(out_valid), 200'(1));
    drive(1, 0, 8'h00, 0, 1);
    cyc();
    chk("release_ov",  200'(out_valid), 200'(0));
    chk("release_idx", 200'(elem_idx),  200'(0));

    // Abort after 30 beats, then reload with -1..-50.
    for (int i = 0; i < 30; i++) begin
      drive(1, 1, 8'($urandom), 0, 0);
      cyc();
    end
    drive(1, 1, 8'h55, 1, 0);
    cyc();
    chk("abort_idx", 200'(elem_idx),  200'(0));
    chk("abort_lb",  200'(loading_b), 200'(0));
    for (int i = 1; i <= 50; i++) begin
      drive(1, 1, 8'(-i), 0, 0);
      cyc();
    end
    chk("abort_reload_ov", 200'(out_valid),   200'(1));
    chk("abort_reload_A0", 200'(A_flat[7:0]), 200'(8'hFF));
    drive(1, 0, 8'h00, 0, 1);
    cyc();

    // Reset mid-B-load.
    for (int i = 0; i < 30; i++) begin
      drive(1, 1, 8'($urandom), 0, 0);
      cyc();
    end
    drive(0, 1, 8'h11, 0, 0);
    cyc();
    chk("rst_A", A_flat, '0);
    chk("rst_B", B_flat, '0);
    chk("rst_idx", 200'(elem_idx), 200'(0));
    chk("rst_lb",  200'(loading_b), 200'(0));
    drive(1, 0, 8'h00, 0, 0);
    cyc();
    chk("rst_release_ready", 200'(in_ready), 200'(1));

    // Random 50% valid, alternating -128/127 per beat offered, random out_ready.
    alt = 8'h80;
    for (int i = 0; i < 400; i++) begin
      drive(1, 1'($urandom_range(0, 1)), alt, 0, ($urandom_range(0, 3) == 0));
      if (in_valid && !m_hold) alt = (alt == 8'h80) ? 8'h7F : 8'h80;
      cyc();
    end

    // Random data with occasional aborts and resets.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0));
      cyc();
    end

`ifdef MATRIX_LOADER_REUSE_B_EN
    drive(0, 0, 8'h00, 0, 0);
    cyc();
    for (int i = 1; i <= 50; i++) begin
      drive(1, 1, 8'(i + 100), 0, 0);
      reuse_b = 1'b0;
      cyc();
    end
    save_b = B_flat;
    drive(1, 0, 8'h00, 0, 1);
    cyc();
    for (int i = 1; i <= 25; i++) begin
      drive(1, 1, 8'(i + 7), 0, 0);
      reuse_b = 1'b1;
      cyc();
      if (i == 24) chk("reuse_ov_early", 200'(out_valid), 200'(0));
    end
    chk("reuse_ov", 200'(out_valid), 200'(1));
    chk("reuse_B",  B_flat, save_b);
    chk("reuse_A0", 200'(A_flat[7:0]), 200'(8));
    reuse_b = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(1, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) == 0));
      reuse_b = 1'($urandom_range(0, 1));
      cyc();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_operand_loader.md
MATRIX_OPERAND_LOADER -- requirements
Module: matrix_operand_loader

Interface
REQ-001 Parameter: none; all sizes come from the shared package (5x5 matrices, 8-bit signed elements, 200-bit flat operand).
REQ-002 clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  in_data holds an element.
REQ-005 in_data  input  8  signed element, row-major, matrix A then matrix B.
REQ-006 in_ready  output  1  loader accepts an element this cycle.
REQ-007 abort  input  1  synchronous discard of the partial load.
REQ-008 A_flat  output  200  matrix A; element (r,c) at bits [r*40+c*8 +: 8].
REQ-009 B_flat  output  200  matrix B; same packing as A_flat.
REQ-010 out_valid  output  1  A_flat and B_flat are complete and stable.
REQ-011 out_ready  input  1  downstream multiplier/ALU has taken the operands.
REQ-012 elem_idx  output  5  index of the next element within the current matrix (0..24).
REQ-013 loading_b  output  1  high while matrix B is being loaded.

Function
REQ-014 States: LOAD_A, LOAD_B, HOLD; the reset state is LOAD_A.
REQ-015 in_ready is 1 in LOAD_A and LOAD_B when abort=0, and 0 in HOLD.
REQ-016 An element is accepted on a cycle with in_valid & in_ready; it is written to byte elem_idx*8 +: 8 of the active matrix, and elem_idx increments.
REQ-017 When element 24 is accepted in LOAD_A, the loader moves to LOAD_B and elem_idx wraps to 0.
REQ-018 When element 24 is accepted in LOAD_B, the loader moves to HOLD; out_valid is 1 from the next cycle on.
REQ-019 out_valid is 1 exactly when the state is HOLD; it is a registered output with no combinational path from any input.
REQ-020 In HOLD, A_flat and B_flat do not change, and in_valid is ignored.
REQ-021 A cycle in HOLD with out_ready=1 moves to LOAD_A with elem_idx=0; out_valid drops on the next cycle.
REQ-022 out_ready outside HOLD has no effect.
REQ-023 Back-to-back elements are accepted at full rate: one per cycle, with no bubble at the A-to-B boundary or after the HOLD release.
REQ-024 The A_flat and B_flat registers are not cleared when a new load starts; each byte changes only when it is overwritten.
REQ-025 Latency: the last B element is accepted on cycle N; out_valid=1 on cycle N+1.
REQ-026 abort=1, in any state: next state LOAD_A, elem_idx=0, no element is written that cycle, and out_valid drops next cycle; abort takes priority over out_ready and in_valid.
REQ-027 loading_b = (state == LOAD_B).

Reset
REQ-028 On rst_n=0 at a clock edge: state=LOAD_A, elem_idx=0, A_flat=0, B_flat=0, out_valid=0, loading_b=0.
REQ-029 in_ready is 0 while rst_n=0, and 1 from the first cycle after release.
REQ-030 A reset during any load discards all partial data; there is no recovery of partial data.

Configuration
REQ-031 Macro MATRIX_LOADER_REUSE_B_EN: when defined, an added input reuse_b (1 bit) is present.
REQ-032 With the macro defined: if reuse_b=1 on the cycle element 24 of A is accepted, the loader goes directly to HOLD and B_flat keeps its previous contents; if reuse_b=0, REQ-017 applies.
REQ-033 Without the macro: the port is absent and every load takes 50 elements.

Structure
REQ-034 Shared package coproc_pkg holds: MAT_DIM=5, ELEM_W=8, ELEM_CNT=25, FLAT_W=200, and the loader state enum.
REQ-035 Sub-module matrix_elem_reg: a 200-bit register with an indexed byte write (wr_en, idx[4:0], data[7:0]) and a synchronous active-low clear; it is instantiated once for A and once for B.

Verification
REQ-036 Stream bytes 1..25 then 26..50 with in_valid held high -> out_valid=1 exactly 1 cycle after the 50th beat; A_flat[7:0]=1, A_flat[199:192]=25, B_flat[7:0]=26.
REQ-037 In HOLD, drive in_valid=1 with data 0x7F for 10 cycles with out_ready=0 -> in_ready=0, flats unchanged, out_valid stays 1; then pulse out_ready for 1 cycle -> next cycle out_valid=0 and elem_idx=0.
REQ-038 Assert abort after 30 accepted beats -> next cycle state LOAD_A, elem_idx=0, loading_b=0; the following 50 beats (values -1..-50) produce A_flat[7:0]=8'hFF.
REQ-039 Drive in_valid randomly at 50% duty with values -128 and 127 alternating -> every element lands at byte index*8 and matches a scoreboard; no element is lost or duplicated.
REQ-040 Pull rst_n low for one cycle mid-B-load -> all outputs return to their reset values on the next cycle, and in_ready=1 one cycle after release.
REQ-041 With MATRIX_LOADER_REUSE_B_EN defined, run a full load, then a second load of 25 elements with reuse_b=1 -> out_valid after the 25th beat, and B_flat equals B from the first load.
